// File: rtl/spi_slave_debug.sv
// SPI mode-0 slave that decodes write/read command frames and drives one rib bus master port.
// SPI pins are oversampled on clk; reads stream out of a one-word prefetch buffer.
module spi_slave_debug #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_clk_i,
    input  logic        spi_ss_i,
    input  logic        spi_mosi_i,
    output logic        spi_miso_o,
    output logic        req_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    input  logic [31:0] rdata_i,
    output logic        frame_done_o
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, WDATA, DUMMY, RDATA, IGNORE
    } state_t;

    // Stages [1:0] synchronize, stage [2] is the previous synchronized value for edge detect.
    // SS resets low so a frame already in progress at reset release is never seen as starting.
    logic [2:0] sclk_sync;
    logic [2:0] ss_sync;
    logic [1:0] mosi_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= 3'b000;
            ss_sync   <= 3'b000;
            mosi_sync <= 2'b00;
        end else begin
            sclk_sync <= {sclk_sync[1:0], spi_clk_i};
            ss_sync   <= {ss_sync[1:0], spi_ss_i};
            mosi_sync <= {mosi_sync[0], spi_mosi_i};
        end
    end

    logic sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_bit;
    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign ss_rise   = ss_sync[1] & ~ss_sync[2];
    assign ss_fall   = ~ss_sync[1] & ss_sync[2];
    assign mosi_bit  = mosi_sync[1];

    state_t      state;
    logic [4:0]  bit_cnt;
    logic [4:0]  fall_cnt;
    logic [30:0] shift;
    logic [30:0] miso_sr;
    logic [31:0] addr;
    logic [31:0] prefetch;
    logic        is_read;
    logic [1:0]  lat;

    logic [31:0] next_word;
    logic [31:0] aligned;
    assign next_word = {shift, mosi_bit};
    assign aligned   = {next_word[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= 5'd0;
            fall_cnt     <= 5'd0;
            shift        <= 31'd0;
            miso_sr      <= 31'd0;
            addr         <= 32'd0;
            prefetch     <= 32'd0;
            is_read      <= 1'b0;
            lat          <= 2'd0;
            spi_miso_o   <= 1'b0;
            req_o        <= 1'b0;
            we_o         <= 1'b0;
            addr_o       <= 32'd0;
            wdata_o      <= 32'd0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;

            // Outstanding requests always run to completion, even across frame boundaries.
            if (req_o) begin
                if (lat == 2'd0) begin
                    req_o <= 1'b0;
                    if (!we_o) prefetch <= rdata_i;
                end else begin
                    lat <= lat - 2'd1;
                end
            end

            if (ss_rise) begin
                frame_done_o <= (state == ADDR) || (state == WDATA) ||
                                (state == DUMMY) || (state == RDATA);
                state      <= IDLE;
                bit_cnt    <= 5'd0;
                fall_cnt   <= 5'd0;
                spi_miso_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ss_fall) begin
                            state    <= CMD;
                            bit_cnt  <= 5'd0;
                            fall_cnt <= 5'd0;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            shift   <= next_word[30:0];
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= 5'd0;
                                if (next_word[7:0] == 8'h02) begin
                                    is_read <= 1'b0;
                                    state   <= ADDR;
                                end else if (next_word[7:0] == 8'h03) begin
                                    is_read <= 1'b1;
                                    state   <= ADDR;
                                end else begin
                                    state <= IGNORE;
                                end
                            end
                        end
                    end
                    ADDR: begin
                        if (sclk_rise) begin
                            shift   <= next_word[30:0];
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd31) begin
                                addr <= aligned;
                                if (is_read) begin
                                    state  <= DUMMY;
                                    req_o  <= 1'b1;
                                    we_o   <= 1'b0;
                                    addr_o <= aligned;
                                    lat    <= 2'(RD_LAT);
                                end else begin
                                    state <= WDATA;
                                end
                            end
                        end
                    end
                    WDATA: begin
                        if (sclk_rise) begin
                            shift   <= next_word[30:0];
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd31) begin
                                req_o   <= 1'b1;
                                we_o    <= 1'b1;
                                addr_o  <= addr;
                                wdata_o <= next_word;
                                lat     <= 2'd0;
                                addr    <= addr + 32'd4;
                            end
                        end
                    end
                    DUMMY: begin
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt  <= 5'd0;
                                fall_cnt <= 5'd0;
                                state    <= RDATA;
                            end
                        end
                    end
                    RDATA: begin
                        if (sclk_fall) begin
                            fall_cnt <= fall_cnt + 5'd1;
                            if (fall_cnt == 5'd0) begin
                                // First bit of a word: drive it and fetch the following word.
                                spi_miso_o <= prefetch[31];
                                miso_sr    <= prefetch[30:0];
                                req_o      <= 1'b1;
                                we_o       <= 1'b0;
                                addr_o     <= addr + 32'd4;
                                lat        <= 2'(RD_LAT);
                                addr       <= addr + 32'd4;
                            end else begin
                                spi_miso_o <= miso_sr[30];
                                miso_sr    <= {miso_sr[29:0], 1'b0};
                            end
                        end
                    end
                    IGNORE: begin
                        spi_miso_o <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_debug.sv
// Directed bench for spi_slave_debug: table of single-word frames plus burst, wrap,
// abort, bad-command and reset-mid-read sequences against a simple rib bus model.
module tb_spi_slave_debug;
    localparam int RD_LAT = 1;
    localparam int HALF = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_clk = 1'b0;
    logic        spi_ss = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        req, we, frame_done;
    logic [31:0] addr, wdata, rdata;

    spi_slave_debug #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_clk_i(spi_clk), .spi_ss_i(spi_ss), .spi_mosi_i(spi_mosi),
        .spi_miso_o(spi_miso),
        .req_o(req), .we_o(we), .addr_o(addr), .wdata_o(wdata),
        .rdata_i(rdata), .frame_done_o(frame_done)
    );

    always #5 clk = ~clk;

    // Bus model: data is valid only in the RD_LAT-th cycle of a request.
    int req_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_cnt <= 0;
        else        req_cnt <= req ? req_cnt + 1 : 0;
    end
    always_comb begin
        rdata = 32'hBAD0_BAD0;
        if (req && req_cnt == RD_LAT) rdata = addr ^ 32'hA5A5_0000;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t act_q[$];
    int   req_len = 0;
    logic last_we = 1'b0;
    int   fd_cnt = 0;
    logic miso_seen = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            req_len = 0;
        end else begin
            if (req) begin
                if (req_len == 0) begin
                    act_q.push_back('{we, addr, wdata});
                    last_we = we;
                end
                req_len++;
            end else if (req_len != 0) begin
                chk("req_len", req_len, last_we ? 32'd1 : RD_LAT + 1);
                req_len = 0;
            end
            if (frame_done) fd_cnt++;
            if (spi_miso) miso_seen = 1'b1;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends the first n bits of v MSB first; miso is sampled just before each rising edge.
    task automatic send_bits(input logic [31:0] v, input int n, output logic [31:0] rx);
        rx = 32'd0;
        for (int i = 0; i < n; i++) begin
            spi_clk = 1'b0;
            spi_mosi = v[31 - i];
            wait_clk(HALF);
            rx = {rx[30:0], spi_miso};
            spi_clk = 1'b1;
            wait_clk(HALF);
        end
    endtask

    task automatic ss_low();
        spi_ss = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic ss_high();
        spi_ss = 1'b1;
        wait_clk(6);
        spi_clk = 1'b0;
        wait_clk(6);
    endtask

    task automatic clear_obs();
        act_q.delete();
        fd_cnt = 0;
        miso_seen = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] frame_addr;
        logic [31:0] data;
        logic [31:0] exp_addr;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[5];
    logic [31:0] rx, rx2;

    initial begin
        vecs[0] = '{8'h02, 32'h1000_0004, 32'hDEAD_BEEF, 32'h1000_0004, 32'hDEAD_BEEF};
        vecs[1] = '{8'h02, 32'h0000_0123, 32'h1234_5678, 32'h0000_0120, 32'h1234_5678};
        vecs[2] = '{8'h02, 32'hFFFF_FFFF, 32'h0F0F_00FF, 32'hFFFF_FFFC, 32'h0F0F_00FF};
        vecs[3] = '{8'h03, 32'h0000_0200, 32'h0,         32'h0000_0200, 32'hA5A5_0200};
        vecs[4] = '{8'h03, 32'h0001_0302, 32'h0,         32'h0001_0300, 32'hA5A4_0300};

        wait_clk(3);
        chk("rst_miso", {31'd0, spi_miso}, 32'd0);
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        rst_n = 1'b1;
        wait_clk(5);

        for (int v = 0; v < 5; v++) begin
            clear_obs();
            ss_low();
            send_bits({vecs[v].cmd, 24'd0}, 8, rx);
            send_bits(vecs[v].frame_addr, 32, rx);
            if (vecs[v].cmd == 8'h02) begin
                send_bits(vecs[v].data, 32, rx);
            end else begin
                send_bits(32'd0, 8, rx);
                send_bits(32'd0, 32, rx);
                chk("vec_miso", rx, vecs[v].exp_word);
            end
            ss_high();
            chk("vec_done", fd_cnt, 32'd1);
            chk("vec_nreq", act_q.size(), (vecs[v].cmd == 8'h02) ? 32'd1 : 32'd2);
            if (act_q.size() >= 1) begin
                chk("vec_we", {31'd0, act_q[0].we}, {31'd0, vecs[v].cmd == 8'h02});
                chk("vec_addr", act_q[0].addr, vecs[v].exp_addr);
                if (vecs[v].cmd == 8'h02) chk("vec_wdata", act_q[0].wdata, vecs[v].exp_word);
            end
            if (act_q.size() >= 2) chk("vec_pf_addr", act_q[1].addr, vecs[v].exp_addr + 32'd4);
        end

        // Two-word read burst: three reads, second word served from prefetch.
        clear_obs();
        ss_low();
        send_bits(32'h0300_0000, 8, rx);
        send_bits(32'h0000_0100, 32, rx);
        send_bits(32'd0, 8, rx);
        send_bits(32'd0, 32, rx);
        send_bits(32'd0, 32, rx2);
        ss_high();
        chk("burst_w0", rx, 32'hA5A5_0100);
        chk("burst_w1", rx2, 32'hA5A5_0104);
        chk("burst_nreq", act_q.size(), 32'd3);
        if (act_q.size() == 3) begin
            chk("burst_a0", act_q[0].addr, 32'h0000_0100);
            chk("burst_a1", act_q[1].addr, 32'h0000_0104);
            chk("burst_a2", act_q[2].addr, 32'h0000_0108);
        end
        chk("burst_done", fd_cnt, 32'd1);

        // Address wrap across the top of the address space.
        clear_obs();
        ss_low();
        send_bits(32'h0200_0000, 8, rx);
        send_bits(32'hFFFF_FFFC, 32, rx);
        send_bits(32'h1111_1111, 32, rx);
        send_bits(32'h2222_2222, 32, rx);
        ss_high();
        chk("wrap_nreq", act_q.size(), 32'd2);
        if (act_q.size() == 2) begin
            chk("wrap_a0", act_q[0].addr, 32'hFFFF_FFFC);
            chk("wrap_d0", act_q[0].wdata, 32'h1111_1111);
            chk("wrap_a1", act_q[1].addr, 32'h0000_0000);
            chk("wrap_d1", act_q[1].wdata, 32'h2222_2222);
        end

        // Partial write word is dropped; the following frame still works.
        clear_obs();
        ss_low();
        send_bits(32'h0200_0000, 8, rx);
        send_bits(32'h0000_0800, 32, rx);
        send_bits(32'hFFFF_FFFF, 20, rx);
        ss_high();
        chk("abort_nreq", act_q.size(), 32'd0);
        clear_obs();
        ss_low();
        send_bits(32'h0200_0000, 8, rx);
        send_bits(32'h0000_0804, 32, rx);
        send_bits(32'hCAFE_F00D, 32, rx);
        ss_high();
        chk("after_abort_nreq", act_q.size(), 32'd1);
        if (act_q.size() == 1) begin
            chk("after_abort_addr", act_q[0].addr, 32'h0000_0804);
            chk("after_abort_data", act_q[0].wdata, 32'hCAFE_F00D);
        end

        // Unknown command: silent frame.
        clear_obs();
        ss_low();
        send_bits(32'h5500_0000, 8, rx);
        send_bits(32'hFFFF_FFFF, 32, rx);
        send_bits(32'hFF00_0000, 8, rx);
        ss_high();
        chk("badcmd_nreq", act_q.size(), 32'd0);
        chk("badcmd_miso", {31'd0, miso_seen}, 32'd0);
        chk("badcmd_done", fd_cnt, 32'd0);

        // Reset in the middle of a read data word.
        clear_obs();
        ss_low();
        send_bits(32'h0300_0000, 8, rx);
        send_bits(32'h0000_0400, 32, rx);
        send_bits(32'd0, 8, rx);
        send_bits(32'd0, 10, rx);
        chk("pre_rst_bits", rx, 32'h0000_0296);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_miso", {31'd0, spi_miso}, 32'd0);
        chk("mid_rst_req", {31'd0, req}, 32'd0);
        chk("mid_rst_we", {31'd0, we}, 32'd0);
        chk("mid_rst_addr", addr, 32'd0);
        chk("mid_rst_wdata", wdata, 32'd0);
        chk("mid_rst_done", {31'd0, frame_done}, 32'd0);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);
        clear_obs();
        send_bits(32'hFFFF_FFFF, 30, rx);
        ss_high();
        chk("stale_nreq", act_q.size(), 32'd0);
        chk("stale_done", fd_cnt, 32'd0);
        clear_obs();
        ss_low();
        send_bits(32'h0300_0000, 8, rx);
        send_bits(32'h0000_0500, 32, rx);
        send_bits(32'd0, 8, rx);
        send_bits(32'd0, 32, rx);
        ss_high();
        chk("post_rst_miso", rx, 32'hA5A5_0500);
        chk("post_rst_nreq", act_q.size(), 32'd2);
        if (act_q.size() >= 1) chk("post_rst_addr", act_q[0].addr, 32'h0000_0500);
        chk("post_rst_done", fd_cnt, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_slave_debug.md
# spi_slave_debug

SPI-slave-to-bus bridge that lets an external SPI master (host adapter, or a second SoC's `spi` master) read and write SoC memory and peripherals. It sits beside `uart_debug` as another debug-download master on the `rib` interconnect. It drives one rib master port (req/we/addr/wdata, rdata back) and decodes a fixed SPI mode-0 command frame. SPI pins are asynchronous to `clk` and are oversampled.

## Interface
- `RD_LAT`, default 1: clk cycles from `req_o` rise to valid `rdata_i` (0 = combinational); legal range 0–3.
- `clk` input 1: system clock; all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `spi_clk_i` input 1: SPI SCLK from the external master, CPOL=0.
- `spi_ss_i` input 1: chip select, active low; a frame is one low period.
- `spi_mosi_i` input 1: master-out data, MSB first.
- `spi_miso_o` output 1: slave-out data, MSB first; 0 whenever not in a read-data phase.
- `req_o` output 1: bus request to rib master port.
- `we_o` output 1: 1 = write, 0 = read; valid while `req_o`=1.
- `addr_o` output 32: bus byte address; always word-aligned (bits [1:0] = 0).
- `wdata_o` output 32: bus write data.
- `rdata_i` input 32: bus read data.
- `frame_done_o` output 1: one-cycle pulse when `spi_ss_i` rises after a valid command byte.

## Operation
- Synchronization: `spi_clk_i`, `spi_ss_i` and `spi_mosi_i` each pass through a 2-flop synchronizer. Edges are detected on the synchronized copies. SCLK high and low times must each be at least 4 clk.
- MOSI is sampled on detected SCLK rising edges. MISO is updated on detected falling edges.
- Frame format, in byte order:
  - CMD: 0x02 = write, 0x03 = read.
  - ADDR: 4 bytes, big-endian. Bits [1:0] are forced to 0.
  - Write: 4-byte data words, big-endian, repeated.
  - Read: 1 dummy byte, then 4-byte data words, repeated.
- States:
  - IDLE: wait for SS falling edge → CMD.
  - CMD: after 8 bits, 0x02/0x03 → ADDR; any other value → IGNORE.
  - ADDR: after 32 bits, write → WDATA. Read → DUMMY, and issue a read of `addr`.
  - WDATA: after each 32 bits, issue a write at `addr`, then `addr` += 4. Stay in WDATA.
  - DUMMY: after 8 bits → RDATA.
  - RDATA: shift out the 32-bit word. When the word's first bit is driven, issue a read of `addr` + 4 into the prefetch buffer, then `addr` += 4.
  - IGNORE: MISO = 0; no bus activity.
- SS rising edge in any state → IDLE. Bit and byte counters clear.
- Bus transaction:
  - `req_o` = 1 for RD_LAT+1 clk for a read, 1 clk for a write.
  - For a read, `rdata_i` is captured on the last `req_o`-high cycle into the prefetch buffer.
  - The buffer loads into the MISO shift register on the falling edge that starts each word.
  - `addr_o` and `wdata_o` hold their value after the request.
- Address increment wraps 0xFFFF_FFFC → 0x0000_0000.
- A partial write word (SS rises before the 32nd data bit) is discarded; no bus write occurs.
- A pending read prefetch always completes even if SS rises; its data is dropped.
- SS falling while a bus request is in flight: the request completes; the new frame is decoded normally.

## Timing
- Reset values: `spi_miso_o`=0, `req_o`=0, `we_o`=0, `addr_o`=0, `wdata_o`=0, `frame_done_o`=0. The FSM resets to IDLE with the prefetch buffer = 0.
- Reset asserted mid-frame: all state clears immediately. After reset releases, the frame in progress is ignored until SS goes high then low again.
- Write latency: `req_o` rises 1 clk after the synchronized rising edge of data bit 0 (the 32nd bit) is detected. That is at most 4 clk after the external SCLK edge.
- Read: the first request is issued within 4 clk of the 32nd address bit. The dummy byte (≥64 clk) guarantees data is buffered before the first data falling edge.
- Prefetch: each prefetch issues ≥ 32 SCLK periods before its data is needed.
- `spi_miso_o` changes within 4 clk after the external SCLK falling edge.
- `frame_done_o` pulses 1 clk after the synchronized SS rise. It does not pulse for IGNORE frames or frames aborted during CMD.

## Test plan
- Write one word: CMD 0x02, ADDR 0x1000_0004, data 0xDEADBEEF, SCLK = clk/8 → exactly one `req_o` pulse with `we_o`=1, `addr_o`=0x1000_0004, `wdata_o`=0xDEADBEEF; `frame_done_o` pulses once.
- Read burst:
  - Stimulus: RD_LAT=1; bus model returns the address XOR 0xA5A5_0000; CMD 0x03, ADDR 0x0000_0100, 1 dummy byte, 64 data SCLKs.
  - Response: MISO carries 0xA5A5_0100 then 0xA5A5_0104.
  - Response: three reads are issued, at 0x100, 0x104 and 0x108.
- Wrap: write burst starting at ADDR 0xFFFF_FFFC with two words 0x11111111, 0x22222222 → writes at 0xFFFF_FFFC then 0x0000_0000.
- Abort: write frame with SS raised after 20 data bits → no `we_o` pulse; the next valid frame executes correctly.
- Bad command: CMD 0x55 plus 40 further bits → no `req_o`, MISO stays 0, no `frame_done_o`.
- Reset mid-read: assert `rst_n`=0 during RDATA bit 10 → all outputs return to reset values immediately. After a fresh SS cycle, a new read returns correct data.
